// File: rtl/io_wait_state_gen.sv
// io_wait_state_gen
// Inserts programmable wait states on I/O and upper-memory bus cycles by
// holding io_channel_ready low for a configured number of clocks. The wait
// counts live in an 8-bit configuration register that is written through an
// I/O port (CFG_PORT). DMA cycles bypass the block and pass ext_ready through.
//
// Optional feature: define IO_WAIT_TIMEOUT_EN to add an 8-bit bus watchdog
// that pulses io_channel_check and forces the bus ready when an expansion
// card holds ext_ready low for too long. Without the macro io_channel_check
// is tied low and a card may stall the bus indefinitely.

module io_wait_state_gen #(
  parameter logic [15:0] CFG_PORT = 16'h00E8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] address,
  input  logic [7:0]  internal_data_bus,
  input  logic        io_read_n,
  input  logic        io_write_n,
  input  logic        memory_read_n,
  input  logic        memory_write_n,
  input  logic        address_enable_n,
  input  logic        ext_ready,
  output logic        io_channel_ready,
  output logic        wait_active,
  output logic        io_channel_check
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  wait_count;

  // Configuration register fields; bit 6 is reserved and not stored
  logic [2:0]  cfg_iow;
  logic [2:0]  cfg_mw;
  logic        cfg_en;

  logic        prev_strobe;
  logic        first_clock;

  logic        io_strobe;
  logic        mem_strobe;
  logic        strobe;
  logic        cycle_start;
  logic        cfg_write;
  logic        upper_memory;
  logic [2:0]  n_waits;
  logic        force_ready;
  logic        data_unused;

  assign io_strobe    = ~(io_read_n & io_write_n);
  assign mem_strobe   = ~(memory_read_n & memory_write_n);
  assign strobe       = (io_strobe | mem_strobe) & address_enable_n;
  assign upper_memory = (address[19:16] >= 4'hA);

  // A held strobe right after reset must not count as a new bus cycle
  assign cycle_start  = strobe & ~prev_strobe & ~first_clock;

  assign cfg_write    = ~io_write_n & address_enable_n & (address[15:0] == CFG_PORT);
  assign data_unused  = internal_data_bus[6];

  // Select the wait count for the cycle that is starting now
  always_comb begin
    n_waits = 3'd0;
    if (cfg_en) begin
      if (io_strobe) begin
        n_waits = cfg_iow;
      end else if (mem_strobe && upper_memory) begin
        n_waits = cfg_mw;
      end
    end
  end

  // Configuration register; the write cycle itself still sees the old value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cfg_iow <= 3'd1;
      cfg_mw  <= 3'd0;
      cfg_en  <= 1'b1;
    end else if (cfg_write) begin
      cfg_iow <= internal_data_bus[2:0];
      cfg_mw  <= internal_data_bus[5:3];
      cfg_en  <= internal_data_bus[7];
    end
  end

  // Strobe edge history plus a one-clock marker for the first clock after reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_strobe <= 1'b0;
      first_clock <= 1'b1;
    end else begin
      prev_strobe <= strobe;
      first_clock <= 1'b0;
    end
  end

`ifdef IO_WAIT_TIMEOUT_EN
  logic [7:0] watchdog;
  logic       timed_out;
  logic       timeout_hit;

  assign timeout_hit = strobe & ~ext_ready & (watchdog == 8'd254) & ~timed_out;
  assign force_ready = timeout_hit | (timed_out & strobe);

  // Watchdog counts stalled clocks within a strobe and latches a timeout
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      watchdog         <= 8'd0;
      timed_out        <= 1'b0;
      io_channel_check <= 1'b0;
    end else begin
      io_channel_check <= timeout_hit;
      if (!strobe) begin
        watchdog  <= 8'd0;
        timed_out <= 1'b0;
      end else begin
        if (!ext_ready && (watchdog != 8'hFF)) begin
          watchdog <= watchdog + 8'd1;
        end
        if (timeout_hit) begin
          timed_out <= 1'b1;
        end
      end
    end
  end
`else
  assign force_ready      = 1'b0;
  assign io_channel_check = 1'b0;
`endif

  // Wait-state FSM; outputs are registered from the next-state decision
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      wait_count       <= 3'd0;
      wait_active      <= 1'b0;
      io_channel_ready <= 1'b1;
    end else begin
      wait_active      <= 1'b0;
      io_channel_ready <= ext_ready | force_ready;
      case (state)
        IDLE: begin
          if (cycle_start) begin
            if (n_waits != 3'd0) begin
              state            <= WAIT;
              wait_count       <= n_waits - 3'd1;
              wait_active      <= 1'b1;
              io_channel_ready <= force_ready;
            end else begin
              state <= DONE;
            end
          end
        end
        WAIT: begin
          if (!strobe) begin
            state      <= IDLE;
            wait_count <= 3'd0;
          end else if (wait_count == 3'd0) begin
            state <= DONE;
          end else begin
            wait_count       <= wait_count - 3'd1;
            wait_active      <= 1'b1;
            io_channel_ready <= force_ready;
          end
        end
        DONE: begin
          if (!strobe) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          wait_count <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_wait_state_gen.sv
// tb_io_wait_state_gen
// Directed bench for io_wait_state_gen. Each driven clock pushes the expected
// ready / wait_active / io_channel_check values onto a scoreboard queue, and
// the following falling edge pops and compares them.

module tb_io_wait_state_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] address;
  logic [7:0]  internal_data_bus;
  logic        io_read_n;
  logic        io_write_n;
  logic        memory_read_n;
  logic        memory_write_n;
  logic        address_enable_n;
  logic        ext_ready;
  logic        io_channel_ready;
  logic        wait_active;
  logic        io_channel_check;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic  rdy;
    logic  wt;
    logic  chk;
    string tag;
  } exp_t;

  exp_t sb[$];

  // Strobe vectors {io_read_n, io_write_n, memory_read_n, memory_write_n}
  localparam logic [3:0] NO_STB = 4'b1111;
  localparam logic [3:0] IO_RD  = 4'b0111;
  localparam logic [3:0] IO_WR  = 4'b1011;
  localparam logic [3:0] MEM_RD = 4'b1101;
  localparam logic [3:0] MEM_WR = 4'b1110;

  io_wait_state_gen #(.CFG_PORT(16'h00E8)) dut (
    .clock             (clock),
    .reset             (reset),
    .address           (address),
    .internal_data_bus (internal_data_bus),
    .io_read_n         (io_read_n),
    .io_write_n        (io_write_n),
    .memory_read_n     (memory_read_n),
    .memory_write_n    (memory_write_n),
    .address_enable_n  (address_enable_n),
    .ext_ready         (ext_ready),
    .io_channel_ready  (io_channel_ready),
    .wait_active       (wait_active),
    .io_channel_check  (io_channel_check)
  );

  always #5 clock = ~clock;

  // Safety net so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic compare(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] strb, input logic aen, input logic ext,
                               input logic [19:0] addr, input logic [7:0] data,
                               input logic e_rdy, input logic e_wt, input logic e_chk,
                               input string tag);
    exp_t e;
    {io_read_n, io_write_n, memory_read_n, memory_write_n} = strb;
    address_enable_n  = aen;
    ext_ready         = ext;
    address           = addr;
    internal_data_bus = data;
    e.rdy = e_rdy;
    e.wt  = e_wt;
    e.chk = e_chk;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(negedge clock);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      compare({e.tag, "_rdy"}, io_channel_ready, e.rdy);
      compare({e.tag, "_wait"}, wait_active, e.wt);
      compare({e.tag, "_chk"}, io_channel_check, e.chk);
    end
  endtask

  // One complete bus cycle: strobe held for 'hold' clocks, then released
  task automatic bus_cycle(input logic [3:0] strb, input logic [19:0] addr,
                           input logic [7:0] data, input int n, input int hold,
                           input string tag);
    for (int i = 0; i < hold; i++) begin
      applyStimulus(strb, 1'b1, 1'b1, addr, data, (i >= n), (i < n), 1'b0,
                    $sformatf("%s_c%0d", tag, i));
      checkOutput();
    end
    applyStimulus(NO_STB, 1'b1, 1'b1, addr, 8'h00, 1'b1, 1'b0, 1'b0, {tag, "_rel"});
    checkOutput();
  endtask

  initial begin
    reset = 1'b1;
    {io_read_n, io_write_n, memory_read_n, memory_write_n} = NO_STB;
    address_enable_n  = 1'b1;
    ext_ready         = 1'b1;
    address           = 20'h0;
    internal_data_bus = 8'h00;
    #1;
    compare("reset_rdy", io_channel_ready, 1'b1);
    compare("reset_wait", wait_active, 1'b0);
    compare("reset_chk", io_channel_check, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 2; i++) begin
      applyStimulus(NO_STB, 1'b1, 1'b1, 20'h0, 8'h00, 1'b1, 1'b0, 1'b0, "idle");
      checkOutput();
    end

    // Reset config gives IOW=1
    bus_cycle(IO_RD, 20'h003F8, 8'h00, 1, 3, "io_rd_rst");

    // Config write 9D uses the old IOW=1, then IOW=5 MW=3
    bus_cycle(IO_WR, 20'h000E8, 8'h9D, 1, 2, "cfg_9d");
    bus_cycle(IO_RD, 20'h003F8, 8'h00, 5, 7, "io_rd_w5");
    bus_cycle(MEM_RD, 20'hB8000, 8'h00, 3, 5, "mem_b8");
    bus_cycle(MEM_RD, 20'h12345, 8'h00, 0, 2, "mem_low");
    bus_cycle(MEM_RD, 20'hA0000, 8'h00, 3, 4, "mem_a0");
    bus_cycle(MEM_RD, 20'h9FFFF, 8'h00, 0, 2, "mem_9f");
    bus_cycle(MEM_WR, 20'hC0000, 8'h00, 3, 4, "memw_c0");

    // Write to a neighbouring port must not touch the config
    bus_cycle(IO_WR, 20'h000E9, 8'h00, 5, 6, "io_wr_e9");
    bus_cycle(IO_RD, 20'h00060, 8'h00, 5, 6, "io_rd_after_e9");

    // Strobe changes type without release: no retrigger
    for (int i = 0; i < 6; i++) begin
      applyStimulus(IO_RD, 1'b1, 1'b1, 20'h003F8, 8'h00, (i >= 5), (i < 5), 1'b0,
                    $sformatf("b2b_rd_c%0d", i));
      checkOutput();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(IO_WR, 1'b1, 1'b1, 20'h003F8, 8'h00, 1'b1, 1'b0, 1'b0,
                    $sformatf("b2b_wr_c%0d", i));
      checkOutput();
    end
    applyStimulus(NO_STB, 1'b1, 1'b1, 20'h0, 8'h00, 1'b1, 1'b0, 1'b0, "b2b_rel");
    checkOutput();

    // Config 07: EN=0 (write itself still IOW=5)
    bus_cycle(IO_WR, 20'h000E8, 8'h07, 5, 6, "cfg_07");
    bus_cycle(IO_WR, 20'h003F8, 8'h00, 0, 3, "io_wr_dis");

    // DMA cycle: ready follows ext_ready one clock later, no waits
    begin
      logic [5:0] ext_pat;
      ext_pat = 6'b110001;
      for (int i = 0; i < 6; i++) begin
        applyStimulus(MEM_RD, 1'b0, ext_pat[i], 20'hB8000, 8'h00, ext_pat[i], 1'b0, 1'b0,
                      $sformatf("dma_c%0d", i));
        checkOutput();
      end
    end
    applyStimulus(NO_STB, 1'b1, 1'b1, 20'h0, 8'h00, 1'b1, 1'b0, 1'b0, "dma_rel");
    checkOutput();

    // Config 87: IOW=7 enabled (write cycle sees EN=0)
    bus_cycle(IO_WR, 20'h000E8, 8'h87, 0, 2, "cfg_87");

    // Abort after 3 wait clocks, then a full 7-wait cycle
    bus_cycle(IO_RD, 20'h003F8, 8'h00, 7, 3, "abort");
    bus_cycle(IO_RD, 20'h003F8, 8'h00, 7, 9, "full7");

    // Card holds ext_ready low for a long time
    for (int i = 0; i < 300; i++) begin
`ifdef IO_WAIT_TIMEOUT_EN
      applyStimulus(IO_RD, 1'b1, 1'b0, 20'h003F8, 8'h00, (i >= 254), (i < 7), (i == 254),
                    $sformatf("stall_c%0d", i));
`else
      applyStimulus(IO_RD, 1'b1, 1'b0, 20'h003F8, 8'h00, 1'b0, (i < 7), 1'b0,
                    $sformatf("stall_c%0d", i));
`endif
      checkOutput();
    end
    applyStimulus(IO_RD, 1'b1, 1'b1, 20'h003F8, 8'h00, 1'b1, 1'b0, 1'b0, "stall_ready");
    checkOutput();
    applyStimulus(NO_STB, 1'b1, 1'b1, 20'h0, 8'h00, 1'b1, 1'b0, 1'b0, "stall_rel");
    checkOutput();

    // Reset during WAIT with the strobe held
    for (int i = 0; i < 2; i++) begin
      applyStimulus(IO_RD, 1'b1, 1'b1, 20'h003F8, 8'h00, 1'b0, 1'b1, 1'b0,
                    $sformatf("rst_pre_c%0d", i));
      checkOutput();
    end
    #2;
    reset = 1'b1;
    #1;
    compare("mid_rst_rdy", io_channel_ready, 1'b1);
    compare("mid_rst_wait", wait_active, 1'b0);
    compare("mid_rst_chk", io_channel_check, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(IO_RD, 1'b1, 1'b1, 20'h003F8, 8'h00, 1'b1, 1'b0, 1'b0,
                    $sformatf("rst_held_c%0d", i));
      checkOutput();
    end
    applyStimulus(NO_STB, 1'b1, 1'b1, 20'h0, 8'h00, 1'b1, 1'b0, 1'b0, "rst_rel");
    checkOutput();

    // Config back at reset value: IOW=1
    bus_cycle(IO_RD, 20'h003F8, 8'h00, 1, 3, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_wait_state_gen.md
IO_WAIT_STATE_GEN -- requirements
Module: io_wait_state_gen

Interface
REQ-001 SHALL have ports: clock  input  1  system bus clock, all state updates on posedge.
REQ-002 SHALL have: reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have: address  input  20  latched bus address.
REQ-004 SHALL have: internal_data_bus  input  8  bus write data (config writes).
REQ-005 SHALL have: io_read_n, io_write_n, memory_read_n, memory_write_n  input  1 each  active-low bus strobes.
REQ-006 SHALL have: address_enable_n  input  1  low = DMA owns the bus.
REQ-007 SHALL have: ext_ready  input  1  ready from the expansion card, high = ready.
REQ-008 SHALL have: io_channel_ready  output  1  ready to the chipset READY logic, registered.
REQ-009 SHALL have: wait_active  output  1  high while inserting internal wait states.
REQ-010 SHALL have: io_channel_check  output  1  one-clock timeout pulse, present only with the REQ-032 macro.
REQ-011 SHALL use parameter CFG_PORT, default 16'h00E8, meaning the I/O address of the wait configuration register.

Function
REQ-012 SHALL hold an 8-bit config register: [2:0] IOW = I/O wait count, [5:3] MW = memory wait count, [7] EN = global enable, [6] reserved (reads 0).
REQ-013 SHALL load the config register on the posedge where io_write_n=0, address_enable_n=1 and address[15:0]=CFG_PORT. The new value applies from the next bus cycle.
REQ-014 SHALL define strobe = ~(io_read_n & io_write_n & memory_read_n & memory_write_n) & address_enable_n.
REQ-015 SHALL detect cycle start as strobe=1 with registered prev_strobe=0.
REQ-016 SHALL select wait count N = IOW for I/O strobes, MW for memory strobes with address[19:16] >= 4'hA, and 0 otherwise or when EN=0.
REQ-017 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-018 IDLE: on cycle start, if N>0 load counter=N-1 and go to WAIT; otherwise go to DONE.
REQ-019 WAIT: internal ready=0. Counter decrements each clock. At counter=0 go to DONE. This gives exactly N clocks with io_channel_ready=0, beginning the clock after cycle start.
REQ-020 DONE: internal ready=1. Return to IDLE when strobe=0.
REQ-021 SHALL drive io_channel_ready = registered (internal ready & ext_ready). Internal ready is 1 in IDLE and DONE.
REQ-022 SHALL set wait_active = 1 only in state WAIT.
REQ-023 Strobe deasserted during WAIT: abort to IDLE, with io_channel_ready=1 on the next clock.
REQ-024 DMA cycles (address_enable_n=0): never leave IDLE, insert no internal waits, and pass ext_ready through.
REQ-025 The config write cycle itself uses the old IOW value.
REQ-026 Back-to-back cycles: a new cycle start requires strobe to return to 1 after being 0. Strobes held continuously do not retrigger.

Reset
REQ-027 On reset, the FSM SHALL go to IDLE, the counter to 0 and prev_strobe to 0.
REQ-028 On reset, the config register SHALL be 8'h81 (IOW=1, MW=0, EN=1).
REQ-029 On reset, io_channel_ready SHALL be 1, wait_active 0 and io_channel_check 0, immediately and asynchronously.
REQ-030 Reset asserted mid-WAIT SHALL abandon the cycle. After release, the held strobe SHALL not start a cycle until it deasserts (prev_strobe is forced to 1 when strobe=1 on the first clock).

Configuration
REQ-031 Macro IO_WAIT_TIMEOUT_EN SHALL compile the feature in or out.
REQ-032 With IO_WAIT_TIMEOUT_EN defined: an 8-bit watchdog counts clocks while strobe=1 and ext_ready=0.
- On reaching 255, the block pulses io_channel_check for 1 clock.
- It then forces io_channel_ready=1 until strobe=0.
- The watchdog clears when strobe=0.
REQ-033 Without IO_WAIT_TIMEOUT_EN: io_channel_check is tied 0, no watchdog logic exists, and ext_ready=0 stalls indefinitely.

Verification
REQ-034 Reset, then I/O read at port 0x3F8 with ext_ready=1 -> io_channel_ready=0 for exactly 1 clock, wait_active=1 for that clock.
REQ-035 Write 8'h9D to 0x00E8, then I/O read -> 5 wait clocks. Memory read at 0xB8000 -> 3 wait clocks. Memory read at 0x12345 -> 0 waits.
REQ-036 Config 8'h07 (EN=0), then I/O write -> io_channel_ready never drops. DMA cycle with ext_ready=0 -> io_channel_ready=0 while ext_ready=0.
REQ-037 IOW=7, strobe released after 3 wait clocks -> io_channel_ready=1 on the next clock and FSM in IDLE. Next strobe -> full 7 waits.
REQ-038 Reset asserted during WAIT with strobe held -> io_channel_ready=1 at once, and no new waits until strobe toggles.
REQ-039 With IO_WAIT_TIMEOUT_EN: I/O read with ext_ready=0 held -> io_channel_check pulses once 255 clocks after cycle start, then io_channel_ready=1 until strobe release.
